// File: rtl/ram_64.sv
// 64 x WIDTH RAM: eight 8-word banks, sync write, combinational read.
// Ports: clk, rst_n (sync, active-low), in, load, address[5:0], out.
module ram_8 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      mem_d[i] = mem_q[i];
      if (load && (address == 3'(i)))
        mem_d[i] = in;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (!rst_n)
        mem_q[i] <= '0;
      else
        mem_q[i] <= mem_d[i];
    end
  end

  assign out = mem_q[address];

endmodule

module ram_64 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [5:0]       address,
  output logic [WIDTH-1:0] out
);

  logic [7:0]       bank_load;
  logic [WIDTH-1:0] bank_out [8];

  always_comb begin
    bank_load = '0;
    bank_load[address[5:3]] = load;
  end

  for (genvar b = 0; b < 8; b++) begin : g_bank
    ram_8 #(.WIDTH(WIDTH)) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .in      (in),
      .load    (bank_load[b]),
      .address (address[2:0]),
      .out     (bank_out[b])
    );
  end

  assign out = bank_out[address[5:3]];

endmodule

// File: tb/tb_ram_64.sv
// Scoreboard bench for ram_64.
// Expected read data queued per read, popped once out settles.
module tb_ram_64;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [5:0]  address;
  logic [15:0] out;

  int n_vec;
  int n_bad;

  logic [15:0] mem_m [64];
  logic [15:0] exp_q [$];
  string       tag_q [$];

  ram_64 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drain();
    logic [15:0] e;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, out, e);
    end
  endtask

  task automatic rd(input string tag,
                    input logic [5:0] a,
                    input logic [15:0] e);
    @(negedge clk);
    load = 1'b0;
    address = a;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    drain();
  endtask

  task automatic wr(input logic [5:0] a,
                    input logic [15:0] d);
    @(negedge clk);
    address = a;
    in = d;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic clr_model();
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    load = 1'b0;
    in = '0;
    address = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_model();

    rd("rst_a0", 6'd0, 16'h0000);
    rd("rst_a5", 6'd5, 16'h0000);
    rd("rst_a63", 6'd63, 16'h0000);
    for (int i = 0; i < 64; i++)
      rd($sformatf("rst_all_%0d", i), 6'(i), 16'h0000);

    wr(6'd0, 16'habcd);
    wr(6'd7, 16'h1001);
    wr(6'd1, 16'h9831);
    wr(6'd2, 16'h9831);
    wr(6'd26, 16'h9831);
    wr(6'd30, 16'h9831);
    wr(6'd15, 16'h9831);

    rd("rb_0", 6'd0, 16'habcd);
    rd("rb_1", 6'd1, 16'h9831);
    rd("rb_7", 6'd7, 16'h1001);
    rd("rb_2", 6'd2, 16'h9831);
    rd("rb_15", 6'd15, 16'h9831);
    rd("rb_26", 6'd26, 16'h9831);
    rd("rb_30", 6'd30, 16'h9831);
    rd("rb_5", 6'd5, 16'h0000);

    @(negedge clk);
    load = 1'b0;
    in = 16'hffff;
    address = 6'd7;
    repeat (3) @(posedge clk);
    rd("gate_7", 6'd7, 16'h1001);

    wr(6'd8, 16'h1234);
    rd("iso_0", 6'd0, 16'habcd);
    rd("iso_8", 6'd8, 16'h1234);
    wr(6'd63, 16'hbeef);
    rd("top_63", 6'd63, 16'hbeef);

    @(negedge clk);
    address = 6'd0;
    in = 16'h5555;
    load = 1'b1;
    #1;
    chk("rdw_before", out, 16'habcd);
    @(posedge clk);
    #1;
    load = 1'b0;
    mem_m[0] = 16'h5555;
    chk("rdw_after", out, 16'h5555);

    for (int i = 0; i < 200; i++)
      wr(6'($urandom_range(0, 63)), 16'($urandom));
    for (int i = 0; i < 64; i++)
      rd($sformatf("rnd_%0d", i), 6'(i), mem_m[i]);

    @(negedge clk);
    rst_n = 1'b0;
    load = 1'b1;
    address = 6'd3;
    in = 16'h7777;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load = 1'b0;
    clr_model();
    rd("rstld_3", 6'd3, 16'h0000);
    for (int i = 0; i < 64; i++)
      rd($sformatf("rstld_all_%0d", i), 6'(i), mem_m[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
